exec_unit_mc: RTL and testbench

- Parametrised successor to the single-issue execute stage.
- Executes one integer, branch or jump op at a time from the issue stage and delivers a registered result plus branch resolution to the memory/writeback stage.
- Adds a valid/ready handshake on both sides, multi-cycle multiply and divide with configurable latency, a generic data width, and pipeline flush.

---
 rtl/exec_pkg.sv | 59 +++++
 rtl/div_iter.sv | 115 +++++++++++
 rtl/exec_unit_mc.sv | 203 ++++++++++++++++++++
 tb/tb_exec_unit_mc.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: opcode and FSM state types plus opcode-class helpers shared by
// the execute unit and its testbench.
package exec_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_LUI    = 5'd10,
    OP_MUL    = 5'd11,
    OP_MULH   = 5'd12,
    OP_MULHSU = 5'd13,
    OP_MULHU  = 5'd14,
    OP_DIV    = 5'd15,
    OP_DIVU   = 5'd16,
    OP_REM    = 5'd17,
    OP_REMU   = 5'd18,
    OP_BEQ    = 5'd19,
    OP_BNE    = 5'd20,
    OP_BLT    = 5'd21,
    OP_BGE    = 5'd22,
    OP_BLTU   = 5'd23,
    OP_BGEU   = 5'd24,
    OP_JAL    = 5'd25,
    OP_JALR   = 5'd26
  } exec_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } exec_state_t;

  // Encodings beyond the last defined opcode execute as ADD.
  function automatic exec_op_t decode_op(logic [4:0] raw);
    return (raw > OP_JALR) ? OP_ADD : exec_op_t'(raw);
  endfunction

  function automatic logic is_mul(exec_op_t o);
    return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div(exec_op_t o);
    return o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_branch(exec_op_t o);
    return o inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per cycle.
// Only built when EXEC_UNIT_DIV_EN is defined; without it the execute unit
// has no divider at all.
`ifdef EXEC_UNIT_DIV_EN
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            signed_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] rem_q, quo_q, dvs_q, dvd_q;
  logic [CW-1:0]   cnt_q;
  logic            run_q, done_q, div0_q, ovf_q, negq_q, negr_q;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] src_r, src_q, src_d, nxt_r, nxt_q;
  logic [XLEN:0]   trial, diff;

  // Operand magnitudes for signed division
  always_comb begin
    a_neg = signed_op && dividend[XLEN-1];
    b_neg = signed_op && divisor[XLEN-1];
    a_abs = a_neg ? -dividend : dividend;
    b_abs = b_neg ? -divisor : divisor;
  end

  // One restoring step; on start it works on the fresh operands so the
  // first quotient bit is produced in the accept cycle itself.
  always_comb begin
    src_r = start ? '0 : rem_q;
    src_q = start ? a_abs : quo_q;
    src_d = start ? b_abs : dvs_q;
    trial = {src_r, src_q[XLEN-1]};
    diff  = trial - {1'b0, src_d};
    if (!diff[XLEN]) begin
      nxt_r = diff[XLEN-1:0];
      nxt_q = {src_q[XLEN-2:0], 1'b1};
    end else begin
      nxt_r = trial[XLEN-1:0];
      nxt_q = {src_q[XLEN-2:0], 1'b0};
    end
  end

  // Iteration control and working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (abort) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= nxt_r;
      quo_q  <= nxt_q;
      dvs_q  <= b_abs;
      dvd_q  <= dividend;
      cnt_q  <= CW'(XLEN - 1);
      run_q  <= 1'b1;
      done_q <= 1'b0;
      div0_q <= (divisor == '0);
      ovf_q  <= signed_op && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
    end else if (run_q) begin
      rem_q <= nxt_r;
      quo_q <= nxt_q;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  // Sign fix-up and divide-by-zero / overflow results
  always_comb begin
    done = done_q;
    if (div0_q) begin
      quotient  = '1;
      remainder = dvd_q;
    end else if (ovf_q) begin
      quotient  = dvd_q;
      remainder = '0;
    end else begin
      quotient  = negq_q ? -quo_q : quo_q;
      remainder = negr_q ? -rem_q : rem_q;
    end
  end

endmodule
`endif

// File: rtl/exec_unit_mc.sv
// exec_unit_mc: single-op execute stage with valid/ready on both sides,
// multi-cycle multiply (MUL_LAT cycles) and optional iterative divide.
// Define EXEC_UNIT_DIV_EN to build the divider; otherwise DIV/DIVU/REM/REMU
// complete in one cycle with an all-ones result.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            jump_taken,
  output logic [XLEN-1:0] jump_dest
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = $clog2(MUL_LAT) + 1;

  exec_state_t     state_q, state_d;
  exec_op_t        op_dec;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            br_taken;
  logic [XLEN-1:0] br_dest;
  logic [XLEN-1:0] result_q, jump_dest_q;
  logic            jump_taken_q;
  logic [CW-1:0]   mul_cnt_q;

`ifdef EXEC_UNIT_DIV_EN
  logic            is_rem_q;
  logic            div_done;
  logic [XLEN-1:0] div_quo, div_rem;
`endif

  function automatic logic [XLEN-1:0] calc(exec_op_t o, logic [XLEN-1:0] a,
                                           logic [XLEN-1:0] b, logic [XLEN-1:0] i,
                                           logic [XLEN-1:0] p);
    logic [2*XLEN-1:0] prod;
    logic [SHW-1:0]    sh;
    logic [XLEN-1:0]   r;
    sh   = b[SHW-1:0];
    prod = '0;
    case (o)
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << sh;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_LUI:  r = i;
      OP_MUL:  r = a * b;
      OP_MULH: begin
        prod = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
        r    = prod[2*XLEN-1:XLEN];
      end
      OP_MULHSU: begin
        prod = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{1'b0}}, b};
        r    = prod[2*XLEN-1:XLEN];
      end
      OP_MULHU: begin
        prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        r    = prod[2*XLEN-1:XLEN];
      end
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = '1;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: r = '0;
      OP_JAL, OP_JALR: r = p + XLEN'(4);
      default: r = a + b;
    endcase
    return r;
  endfunction

  function automatic exec_state_t dispatch(exec_op_t o);
    if (is_mul(o)) return (MUL_LAT == 1) ? DONE : MUL;
`ifdef EXEC_UNIT_DIV_EN
    if (is_div(o)) return DIV;
`endif
    return DONE;
  endfunction

  assign op_dec = decode_op(op);
  assign accept = in_valid && in_ready;

  // Single-cycle ALU result, also the full product for multiplies
  always_comb begin
    alu_res = calc(op_dec, rs1, rs2, imm, pc);
  end

  // Branch and jump resolution
  always_comb begin
    br_taken = 1'b0;
    br_dest  = '0;
    case (op_dec)
      OP_BEQ:          br_taken = (rs1 == rs2);
      OP_BNE:          br_taken = (rs1 != rs2);
      OP_BLT:          br_taken = ($signed(rs1) < $signed(rs2));
      OP_BGE:          br_taken = ($signed(rs1) >= $signed(rs2));
      OP_BLTU:         br_taken = (rs1 < rs2);
      OP_BGEU:         br_taken = (rs1 >= rs2);
      OP_JAL, OP_JALR: br_taken = 1'b1;
      default:         br_taken = 1'b0;
    endcase
    if (br_taken) begin
      br_dest = (op_dec == OP_JALR) ? ((rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0})
                                    : (pc + imm);
    end
  end

`ifdef EXEC_UNIT_DIV_EN
  div_iter #(
    .XLEN(XLEN)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div(op_dec)),
    .abort     (flush),
    .signed_op (op_dec inside {OP_DIV, OP_REM}),
    .dividend  (rs1),
    .divisor   (rs2),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = dispatch(op_dec);
        MUL:  if (mul_cnt_q == CW'(1)) state_d = DONE;
`ifdef EXEC_UNIT_DIV_EN
        DIV:  if (div_done) state_d = DONE;
`else
        DIV:  state_d = IDLE;
`endif
        DONE: if (out_ready) state_d = accept ? dispatch(op_dec) : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs
  always_comb begin
    in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    out_valid = (state_q == DONE);
  end

  // Result registers; a multiply's product is latched at accept and simply
  // held while the latency counter runs down.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q     <= '0;
      jump_taken_q <= 1'b0;
      jump_dest_q  <= '0;
      mul_cnt_q    <= '0;
`ifdef EXEC_UNIT_DIV_EN
      is_rem_q     <= 1'b0;
`endif
    end else if (accept) begin
      result_q     <= alu_res;
      jump_taken_q <= br_taken;
      jump_dest_q  <= br_dest;
      mul_cnt_q    <= CW'(MUL_LAT - 1);
`ifdef EXEC_UNIT_DIV_EN
      is_rem_q     <= op_dec inside {OP_REM, OP_REMU};
`endif
    end else begin
      if (state_q == MUL) mul_cnt_q <= mul_cnt_q - 1'b1;
`ifdef EXEC_UNIT_DIV_EN
      if ((state_q == DIV) && div_done && !flush) result_q <= is_rem_q ? div_rem : div_quo;
`endif
    end
  end

  assign result     = result_q;
  assign jump_taken = jump_taken_q;
  assign jump_dest  = jump_dest_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: directed and random checks of exec_unit_mc against a
// plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_exec_unit_mc;
  import exec_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MUL_LAT = 3;
`ifdef EXEC_UNIT_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, jump_taken;
  logic [4:0]  op;
  logic [31:0] pc, imm, rs1, rs2, result, jump_dest;

  int n_assert = 0;
  int n_fail   = 0;

  exec_unit_mc #(
    .XLEN    (XLEN),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .pc         (pc),
    .imm        (imm),
    .rs1        (rs1),
    .rs2        (rs2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .jump_taken (jump_taken),
    .jump_dest  (jump_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (observed timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed directly from the instruction semantics.
  task automatic model(input logic [4:0] raw, input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic jt, output logic [31:0] jd,
                       output int lat);
    longint      sa, sb;
    logic [63:0] prod;
    logic [4:0]  o;
    bit          take;
    o    = (raw > 5'd26) ? 5'd0 : raw;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    res  = 32'h0;
    jt   = 1'b0;
    jd   = 32'h0;
    lat  = 1;
    take = 1'b0;
    case (exec_op_t'(o))
      OP_SUB:  res = a - b;
      OP_SLL:  res = a << b[4:0];
      OP_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  res = a ^ b;
      OP_SRL:  res = a >> b[4:0];
      OP_SRA:  res = 32'(sa >>> b[4:0]);
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_LUI:  res = i;
      OP_MUL:    begin prod = 64'(a) * 64'(b); res = prod[31:0];  lat = MUL_LAT; end
      OP_MULH:   begin prod = sa * sb;          res = prod[63:32]; lat = MUL_LAT; end
      OP_MULHSU: begin prod = sa * longint'({32'h0, b}); res = prod[63:32]; lat = MUL_LAT; end
      OP_MULHU:  begin prod = 64'(a) * 64'(b); res = prod[63:32]; lat = MUL_LAT; end
      OP_DIV: begin
        if (b == 32'h0)                             res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
        else                                        res = 32'(sa / sb);
      end
      OP_DIVU: res = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'h0)                             res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h0;
        else                                        res = 32'(sa % sb);
      end
      OP_REMU: res = (b == 32'h0) ? a : a % b;
      OP_BEQ:  take = (a == b);
      OP_BNE:  take = (a != b);
      OP_BLT:  take = (sa < sb);
      OP_BGE:  take = (sa >= sb);
      OP_BLTU: take = (a < b);
      OP_BGEU: take = (a >= b);
      OP_JAL:  begin res = p + 32'd4; jt = 1'b1; jd = p + i; end
      OP_JALR: begin res = p + 32'd4; jt = 1'b1; jd = (a + i) & 32'hFFFF_FFFE; end
      default: res = a + b;
    endcase
    if (o >= 5'd15 && o <= 5'd18) begin
      if (DIV_EN) lat = XLEN + 1;
      else        res = 32'hFFFF_FFFF;
    end
    if (take) begin
      jt = 1'b1;
      jd = p + i;
    end
  endtask

  // Issue one op from idle, measure latency to out_valid, check, then consume.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] p,
                        input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_res, e_jd;
    logic        e_jt;
    int          e_lat, lat;
    model(o, p, i, a, b, e_res, e_jt, e_jd, e_lat);
    op = o; pc = p; imm = i; rs1 = a; rs2 = b;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    check({tag, "/latency"}, 32'(lat), 32'(e_lat));
    check({tag, "/result"}, result, e_res);
    check({tag, "/jump_taken"}, 32'(jump_taken), 32'(e_jt));
    check({tag, "/jump_dest"}, jump_dest, e_jd);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 9));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 5'd0; pc = 32'h0; imm = 32'h0; rs1 = 32'h0; rs2 = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/result", result, 32'h0);
    check("rst/jump_taken", 32'(jump_taken), 32'd0);
    check("rst/jump_dest", jump_dest, 32'h0);
    check("rst/in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // ADD 5+7, then hold for three cycles while another op is offered
    op = OP_ADD; rs1 = 32'd5; rs2 = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    op = OP_SUB; rs1 = 32'd100; rs2 = 32'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold/out_valid", 32'(out_valid), 32'd1);
      check("hold/result", result, 32'd12);
      check("hold/jump_taken", 32'(jump_taken), 32'd0);
      check("hold/in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("hold/not_accepted", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // back-to-back ADD / SUB / SRA at one op per cycle
    op = OP_ADD; rs1 = 32'd10; rs2 = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    op = OP_SUB;
    @(negedge clk);
    check("b2b/add_valid", 32'(out_valid), 32'd1);
    check("b2b/add", result, 32'd13);
    check("b2b/in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    op = OP_SRA; rs1 = 32'h8000_0000; rs2 = 32'd4;
    @(negedge clk);
    check("b2b/sub_valid", 32'(out_valid), 32'd1);
    check("b2b/sub", result, 32'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b/sra_valid", 32'(out_valid), 32'd1);
    check("b2b/sra", result, 32'hF800_0000);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // multiply, divide corner cases, branch and jump resolution
    run_op("mulhu", OP_MULHU, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh", OP_MULH, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0003);
    run_op("div_ovf", OP_DIV, 32'h0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_0", OP_DIVU, 32'h0, 32'h0, 32'd7, 32'd0);
    run_op("rem_0", OP_REM, 32'h0, 32'h0, 32'd7, 32'd0);
    run_op("rem_neg", OP_REM, 32'h0, 32'h0, 32'hFFFF_FFF9, 32'd2);
    run_op("blt", OP_BLT, 32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h0);
    run_op("jalr", OP_JALR, 32'h400, 32'h0, 32'h203, 32'h0);
    run_op("beq_ne", OP_BEQ, 32'h100, 32'h40, 32'd1, 32'd2);
    run_op("jal_wrap", OP_JAL, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0);
    run_op("undef", 5'd30, 32'h0, 32'h0, 32'd40, 32'd2);

    // flush at cycle 10 of a divide while a new op is offered
    op = OP_DIV; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = OP_ADD; rs1 = 32'd1; rs2 = 32'd2; out_ready = 1'b1;
    @(negedge clk);
    check("flush/in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush/no_valid", 32'(seen), 32'd0);
    @(posedge clk); #1;
    run_op("after_flush", OP_ADD, 32'h0, 32'h0, 32'd21, 32'd21);

    // flush in the middle of a multiply
    op = OP_MUL; rs1 = 32'd6; rs2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_mul/no_valid", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // reset while a taken jump result is held
    op = OP_JAL; pc = 32'h1000; imm = 32'h80; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid/held_jt", 32'(jump_taken), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid/out_valid", 32'(out_valid), 32'd0);
    check("rst_mid/result", result, 32'h0);
    check("rst_mid/jump_taken", 32'(jump_taken), 32'd0);
    check("rst_mid/jump_dest", jump_dest, 32'h0);
    @(posedge clk); #1;

    // random ops, including undefined encodings
    for (int k = 0; k < 150; k++) begin
      run_op("rand", 5'($urandom_range(0, 31)), 32'($urandom), rnd_operand(),
             rnd_operand(), rnd_operand());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
